addr_seq: RTL and testbench

- Parametrised successor to the CPU address selector: generates the fetch/execute bus phasing internally and selects between three address sources (PC, IR operand, DMA).
- Registers the selected address once per half-cycle, so ROM/RAM/port see an address that stays stable through each half.
- Sits between the PC/IR/DMA address producers and the shared memory/port address bus. It replaces the free-running divide-by-8 fetch signal plus the combinational selector.

---
 rtl/addr_seq.sv | 170 +++++++++++++++++
 tb/tb_addr_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/addr_seq.sv
// addr_seq: instruction-cycle sequencer and bus address selector.
//
// Generates the fetch/execute phasing of each instruction cycle and drives a
// registered address onto the shared memory/port bus. The address is loaded
// only at half boundaries (start of fetch, start of execute), so downstream
// ROM/RAM/ports see a value that is stable for the whole half.
//
// Parameters:
//   AW      address width in bits
//   PHASES  clocks per instruction cycle (even, >= 4); first half is fetch
//   PW      phase counter width (derived, not overridable)
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          synchronous reset, active-high
//   i_en           run enable, sampled only at cycle boundaries
//   i_pc_addr      program counter address (fetch source)
//   i_ir_addr      operand address (CPU execute source)
//   i_data_idle    current instruction makes no data access in execute
//   i_dma_req      DMA requests the execute half
//   i_dma_addr     DMA address
//   o_addr         registered bus address
//   o_fetch        high during the fetch half
//   o_phase        current phase index 0..PHASES-1
//   o_cycle_start  high during phase 0 of fetch
//   o_dma_gnt      high during an execute half owned by DMA
//   o_src          address owner: 0 PC, 1 IR, 2 DMA, 3 none
module addr_seq #(
    parameter  int AW     = 13,
    parameter  int PHASES = 8,
    localparam int PW     = $clog2(PHASES)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic [AW-1:0] i_pc_addr,
    input  logic [AW-1:0] i_ir_addr,
    input  logic          i_data_idle,
    input  logic          i_dma_req,
    input  logic [AW-1:0] i_dma_addr,
    output logic [AW-1:0] o_addr,
    output logic          o_fetch,
    output logic [PW-1:0] o_phase,
    output logic          o_cycle_start,
    output logic          o_dma_gnt,
    output logic [1:0]    o_src
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    localparam logic [PW-1:0] LP_FETCH_LAST = PW'(PHASES / 2 - 1);
    localparam logic [PW-1:0] LP_EXEC_LAST  = PW'(PHASES - 1);
    localparam logic [PW-1:0] LP_PHASE_ONE  = PW'(1);

    localparam logic [1:0] LP_SRC_PC   = 2'd0;
    localparam logic [1:0] LP_SRC_IR   = 2'd1;
    localparam logic [1:0] LP_SRC_DMA  = 2'd2;
    localparam logic [1:0] LP_SRC_NONE = 2'd3;

    state_t        r_state;
    logic [PW-1:0] r_phase;
    logic [AW-1:0] r_addr;
    logic          r_fetch;
    logic          r_cycle_start;
    logic          r_dma_gnt;
    logic [1:0]    r_src;

    state_t        w_state_nxt;
    logic [PW-1:0] w_phase_nxt;
    logic [AW-1:0] w_addr_nxt;
    logic          w_dma_gnt_nxt;
    logic [1:0]    w_src_nxt;

    // Next-state decode: phase advance, boundary decisions and address capture.
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_addr_nxt    = r_addr;
        w_dma_gnt_nxt = r_dma_gnt;
        w_src_nxt     = r_src;
        case (r_state)
            ST_IDLE: begin
                w_phase_nxt   = {PW{1'b0}};
                w_dma_gnt_nxt = 1'b0;
                if (i_en) begin
                    w_state_nxt = ST_FETCH;
                    w_addr_nxt  = i_pc_addr;
                    w_src_nxt   = LP_SRC_PC;
                end else begin
                    // Address bus deliberately holds its last value while idle.
                    w_src_nxt = LP_SRC_NONE;
                end
            end
            ST_FETCH: begin
                w_phase_nxt = r_phase + LP_PHASE_ONE;
                if (r_phase == LP_FETCH_LAST) begin
                    w_state_nxt = ST_EXEC;
                    // DMA only takes an execute half the CPU does not need.
                    if (i_dma_req && i_data_idle) begin
                        w_addr_nxt    = i_dma_addr;
                        w_src_nxt     = LP_SRC_DMA;
                        w_dma_gnt_nxt = 1'b1;
                    end else begin
                        w_addr_nxt    = i_ir_addr;
                        w_src_nxt     = LP_SRC_IR;
                        w_dma_gnt_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (r_phase == LP_EXEC_LAST) begin
                    w_phase_nxt   = {PW{1'b0}};
                    w_dma_gnt_nxt = 1'b0;
                    if (i_en) begin
                        w_state_nxt = ST_FETCH;
                        w_addr_nxt  = i_pc_addr;
                        w_src_nxt   = LP_SRC_PC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_src_nxt   = LP_SRC_NONE;
                    end
                end else begin
                    w_phase_nxt = r_phase + LP_PHASE_ONE;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_phase_nxt   = {PW{1'b0}};
                w_dma_gnt_nxt = 1'b0;
                w_src_nxt     = LP_SRC_NONE;
            end
        endcase
    end

    // State and output registers; fetch/cycle_start are decoded from the next
    // state so they come straight from flops and cannot glitch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_phase       <= {PW{1'b0}};
            r_addr        <= {AW{1'b0}};
            r_fetch       <= 1'b0;
            r_cycle_start <= 1'b0;
            r_dma_gnt     <= 1'b0;
            r_src         <= LP_SRC_NONE;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            r_addr        <= w_addr_nxt;
            r_fetch       <= (w_state_nxt == ST_FETCH);
            r_cycle_start <= (w_state_nxt == ST_FETCH) && (w_phase_nxt == {PW{1'b0}});
            r_dma_gnt     <= w_dma_gnt_nxt;
            r_src         <= w_src_nxt;
        end
    end

    assign o_addr        = r_addr;
    assign o_fetch       = r_fetch;
    assign o_phase       = r_phase;
    assign o_cycle_start = r_cycle_start;
    assign o_dma_gnt     = r_dma_gnt;
    assign o_src         = r_src;

endmodule

// File: tb/tb_addr_seq.sv
// tb_addr_seq: drives two addr_seq instances (AW=13/PHASES=8 and
// AW=16/PHASES=4) from shared stimulus and compares every output after each
// clock edge against a cycle-position model of the instruction cycle.
module tb_addr_seq;

    logic        clk = 1'b0;
    logic        rst, en, data_idle, dma_req;
    logic [15:0] pc, ir, dma;

    logic [12:0] a_addr;
    logic        a_fetch, a_cs, a_gnt;
    logic [2:0]  a_phase;
    logic [1:0]  a_src;

    logic [15:0] b_addr;
    logic        b_fetch, b_cs, b_gnt;
    logic [1:0]  b_phase;
    logic [1:0]  b_src;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per instance, whether a cycle is running, position within it,
    // and the bus owner/address latched at the last half boundary.
    int m_run  [2];
    int m_pos  [2];
    int m_addr [2];
    int m_src  [2];
    int m_gnt  [2];
    int phs    [2] = '{8, 4};
    int amask  [2] = '{32'h1FFF, 32'hFFFF};

    always #5 clk = ~clk;

    addr_seq #(.AW(13), .PHASES(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .i_pc_addr(pc[12:0]), .i_ir_addr(ir[12:0]),
        .i_data_idle(data_idle), .i_dma_req(dma_req), .i_dma_addr(dma[12:0]),
        .o_addr(a_addr), .o_fetch(a_fetch), .o_phase(a_phase),
        .o_cycle_start(a_cs), .o_dma_gnt(a_gnt), .o_src(a_src)
    );

    addr_seq #(.AW(16), .PHASES(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .i_pc_addr(pc), .i_ir_addr(ir),
        .i_data_idle(data_idle), .i_dma_req(dma_req), .i_dma_addr(dma),
        .o_addr(b_addr), .o_fetch(b_fetch), .o_phase(b_phase),
        .o_cycle_start(b_cs), .o_dma_gnt(b_gnt), .o_src(b_src)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int nxt;
            nxt = m_pos[k] + 1;
            if (rst) begin
                m_run[k] = 0; m_pos[k] = 0; m_addr[k] = 0; m_src[k] = 3; m_gnt[k] = 0;
            end else if (m_run[k] == 0) begin
                if (en) begin
                    m_run[k] = 1; m_pos[k] = 0; m_addr[k] = int'(pc) & amask[k];
                    m_src[k] = 0; m_gnt[k] = 0;
                end
            end else if (nxt == phs[k] / 2) begin
                m_pos[k] = nxt;
                if (dma_req && data_idle) begin
                    m_addr[k] = int'(dma) & amask[k]; m_src[k] = 2; m_gnt[k] = 1;
                end else begin
                    m_addr[k] = int'(ir) & amask[k]; m_src[k] = 1; m_gnt[k] = 0;
                end
            end else if (nxt == phs[k]) begin
                m_pos[k] = 0; m_gnt[k] = 0;
                if (en) begin
                    m_addr[k] = int'(pc) & amask[k]; m_src[k] = 0;
                end else begin
                    m_run[k] = 0; m_src[k] = 3;
                end
            end else begin
                m_pos[k] = nxt;
            end
        end
    endtask

    function automatic logic [15:0] exp_fetch(int k);
        return (m_run[k] == 1 && m_pos[k] < phs[k] / 2) ? 16'd1 : 16'd0;
    endfunction

    function automatic logic [15:0] exp_cs(int k);
        return (m_run[k] == 1 && m_pos[k] == 0) ? 16'd1 : 16'd0;
    endfunction

    task automatic check_all();
        chk("A.addr",  {3'd0, a_addr},   16'(m_addr[0]));
        chk("A.fetch", {15'd0, a_fetch}, exp_fetch(0));
        chk("A.phase", {13'd0, a_phase}, 16'(m_pos[0]));
        chk("A.cs",    {15'd0, a_cs},    exp_cs(0));
        chk("A.gnt",   {15'd0, a_gnt},   16'(m_gnt[0]));
        chk("A.src",   {14'd0, a_src},   16'(m_src[0]));
        chk("B.addr",  b_addr,           16'(m_addr[1]));
        chk("B.fetch", {15'd0, b_fetch}, exp_fetch(1));
        chk("B.phase", {14'd0, b_phase}, 16'(m_pos[1]));
        chk("B.cs",    {15'd0, b_cs},    exp_cs(1));
        chk("B.gnt",   {15'd0, b_gnt},   16'(m_gnt[1]));
        chk("B.src",   {14'd0, b_src},   16'(m_src[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Step until instance A is running at the given phase, within a bounded budget.
    task automatic wait_pos(input int target);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 32 && !found; i++) begin
            if (m_run[0] == 1 && m_pos[0] == target) found = 1'b1;
            else step();
        end
        chk("wait_phase", {15'd0, found}, 16'd1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; data_idle = 1'b0; dma_req = 1'b0;
        pc = 16'h0000; ir = 16'h0000; dma = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_pos[k] = 0; m_addr[k] = 0; m_src[k] = 3; m_gnt[k] = 0;
        end
        step();
        step();
        chk("reset_src", {14'd0, a_src}, 16'd3);

        // Basic cycle; pc changes mid-fetch and must not disturb the bus.
        rst = 1'b0; en = 1'b1; pc = 16'h0010; ir = 16'h1ABC;
        step();
        chk("tp_fetch_addr", {3'd0, a_addr}, 16'h0010);
        chk("tp_cs_phase0", {15'd0, a_cs}, 16'd1);
        step();
        step();
        pc = 16'h0FFF;
        step();
        chk("tp_addr_held", {3'd0, a_addr}, 16'h0010);
        step();
        chk("tp_exec_addr", {3'd0, a_addr}, 16'h1ABC);
        repeat (3) step();
        step();
        chk("tp_next_pc", {3'd0, a_addr}, 16'h0FFF);

        // DMA grant on a data-idle execute half, then refused when data is used.
        dma_req = 1'b1; data_idle = 1'b1; dma = 16'h1F00;
        wait_pos(4);
        chk("tp_dma_addr", {3'd0, a_addr}, 16'h1F00);
        chk("tp_dma_gnt", {15'd0, a_gnt}, 16'd1);
        wait_pos(0);
        data_idle = 1'b0;
        wait_pos(4);
        chk("tp_nodma_addr", {3'd0, a_addr}, 16'h1ABC);

        // DMA request pulsed only at a non-boundary phase.
        dma_req = 1'b0; data_idle = 1'b1;
        wait_pos(5);
        dma_req = 1'b1;
        step();
        dma_req = 1'b0;
        wait_pos(4);
        chk("tp_pulse_nognt", {15'd0, a_gnt}, 16'd0);

        // en dropped mid-cycle: the cycle completes, then idle.
        wait_pos(2);
        en = 1'b0;
        repeat (6) step();
        chk("tp_idle_src", {14'd0, a_src}, 16'd3);
        repeat (3) step();
        en = 1'b1;
        step();
        chk("tp_restart", {15'd0, a_fetch}, 16'd1);

        // Reset in the middle of a DMA-owned execute half.
        dma_req = 1'b1; data_idle = 1'b1; dma = 16'h1234;
        wait_pos(5);
        chk("tp_gnt_before_rst", {15'd0, a_gnt}, 16'd1);
        rst = 1'b1;
        step();
        chk("tp_rst_addr", {3'd0, a_addr}, 16'h0000);
        rst = 1'b0; dma_req = 1'b0;

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 59) == 0);
            en        = ($urandom_range(0, 9) != 0);
            dma_req   = 1'($urandom_range(0, 1));
            data_idle = 1'($urandom_range(0, 1));
            pc        = 16'($urandom);
            ir        = 16'($urandom);
            dma       = 16'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
